// File: rtl/aes_pkg.sv
// AES byte-substitution tables and lookup helpers shared by the datapath.
package aes_pkg;

  localparam int AES_BYTE = 8;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane: combinational forward/inverse S-box lookup.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  // With INV_EN=0 the inverse branch is constant-false and the table drops out.
  always_comb begin
    dout = sbox_fwd(din);
    if ((INV_EN != 0) && inv) dout = sbox_inv(din);
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES SubBytes/InvSubBytes with valid/ready flow control.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int INV_EN      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AES_BYTE*LANES-1:0] in_data,
  input  logic                      in_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AES_BYTE*LANES-1:0] out_data,
  output logic                      out_inv
);

  localparam int W    = AES_BYTE * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  logic [W-1:0]             lut;
  logic                     lut_inv;
  logic [PIPE_STAGES-1:0]   vld_pipe;
  logic [PIPE_STAGES-1:0]   inv_pipe;
  logic [W-1:0]             dat_pipe [PIPE_STAGES];
  logic [PIPE_STAGES:0]     rdy;

  // Mode bit is forced to forward when the inverse table is not built.
  assign lut_inv = (INV_EN != 0) && in_inv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .din  (in_data[AES_BYTE*i +: AES_BYTE]),
      .inv  (lut_inv),
      .dout (lut[AES_BYTE*i +: AES_BYTE])
    );
  end

  // Ready ripples back from the output: a stage can take a word if it is
  // empty or the stage after it can take its current word.
  always_comb begin
    rdy              = '0;
    rdy[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) rdy[k] = !vld_pipe[k] || rdy[k+1];
  end

  // Stage registers: stage 0 captures the lookup, later stages transfer.
  // Data only moves with a valid word, so bubbles never overwrite contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      inv_pipe <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) dat_pipe[k] <= '0;
    end else begin
      if (rdy[0]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          dat_pipe[0] <= lut;
          inv_pipe[0] <= lut_inv;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) begin
            dat_pipe[k] <= dat_pipe[k-1];
            inv_pipe[k] <= inv_pipe[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[LAST];
  assign out_data  = dat_pipe[LAST];
  assign out_inv   = inv_pipe[LAST];

endmodule

// File: doc/aes_sbox_pipe.md
Name: aes_sbox_pipe

Overview:
- Parametrised, pipelined AES byte-substitution block that processes LANES bytes per transaction, in forward (SubBytes) or inverse (InvSubBytes) mode.
- It generalises the single-byte combinational forward S-box with four additions: multiple lanes, a per-transaction mode bit, registered pipeline stages, and a valid/ready handshake.
- Sits in the AES datapath between AddRoundKey and ShiftRows.
- With LANES=4 it also serves as the SubWord unit in key expansion.

Parameters:
- LANES, 4, number of independent byte lanes (1..16).
- PIPE_STAGES, 2, register stages from the input handshake to the output (1..4).
- INV_EN, 1, 1 builds the inverse table; 0 omits it, and in_inv is then ignored (forward only).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_data  input  8*LANES  lane i = in_data[8i+7:8i].
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*LANES  substituted bytes, same lane order as in_data.
- out_inv  output  1  echo of the in_inv bit that travelled with this transaction.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: every stage valid bit = 0, so out_valid = 0. out_data = 0 and out_inv = 0. in_ready = 1 in the first cycle after rst deasserts.
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Lookup is combinational on in_data/in_inv and is captured into the stage-0 register. Stages 1..PIPE_STAGES-1 are pure transfer registers.
- Latency: a word accepted at edge t has out_valid=1 after edge t+PIPE_STAGES-1 (i.e. PIPE_STAGES register stages), provided no stall occurs.
- Throughput: one transaction per cycle when out_ready is held high.
- Stall chain: ready_last = out_ready || !v[last]; ready_k = !v[k] || ready_{k+1}; in_ready = ready_0.
  - A stage loads only when its own ready is high.
  - A stalled stage holds its data and inv bit unchanged.
  - The combinational ready path is permitted.
- Simultaneous emit and accept with the pipeline full: both happen in the same cycle, with no bubble and no loss.
- Capacity is PIPE_STAGES words. When all stages are valid and out_ready=0, in_ready=0.
- out_data, out_inv and out_valid must not change while out_valid=1 && out_ready=0.
- Each lane is substituted independently. Lane results never mix; any byte in any lane position is legal.
- Mode is per transaction. Mixing forward and inverse words back-to-back is legal, and each result follows its own inv bit.
- With INV_EN=0: out_inv = 0 and the result is always forward.
- rst mid-operation: all in-flight words are discarded. Nothing is emitted afterwards except newly accepted words.
- in_data is ignored when in_valid=0. Stage registers do not load bubbles as data.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry forward table constant SBOX_FWD;
  - the 256-entry inverse table constant SBOX_INV;
  - functions sbox_fwd(byte) and sbox_inv(byte);
  - the AES_BYTE width constant = 8.
- Sub-module aes_sbox_lane: combinational; inputs 8-bit byte and inv; output 8-bit result; parameter INV_EN. It is instantiated LANES times via generate.
- The top level holds only the pipeline registers, valid bits and ready chain.

Test Plan:
- LANES=4, forward, in_data=32'h01_00_53_FF, out_ready=1 -> out_data=32'h7C_63_ED_16, out_inv=0, appearing PIPE_STAGES cycles after accept.
- Inverse, in_data=32'h7C_63_ED_16, in_inv=1 -> out_data=32'h01_00_53_FF, out_inv=1. Also send alternating fwd/inv words back-to-back and check each result against its own mode.
- Exhaustive check, all 256 byte values in every lane: forward against the table (e.g. 0x9A->0xB8, 0xC7->0xC6). Round trip inv(fwd(x))=x.
- Backpressure: stream 8 words and hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once PIPE_STAGES words are held, out_data is stable while stalled, all 8 results arrive in order with no loss or duplication.
- Reset: assert rst for 1 cycle with 2 words in flight -> out_valid=0 and out_data=0 next cycle, in-flight words are never emitted, and the next accepted word (0x00 -> 0x63) emits normally.
- INV_EN=0 build, in_inv=1, in_data=0x63 per lane -> out_data=0xFB per lane, out_inv=0.
